// File: rtl/hilo_unit_pkg.sv
// Shared constants and types for the HI/LO register pair and its
// iterative divider.
package hilo_unit_pkg;

  // Architectural data width used across the datapath.
  localparam int HILO_LENGTH = 32;

  // FSM state encodings, kept as plain 2-bit constants so they can be
  // mirrored by the legacy header defines.
  localparam logic [1:0] HILO_IDLE = 2'd0;
  localparam logic [1:0] HILO_RUN  = 2'd1;
  localparam logic [1:0] HILO_DONE = 2'd2;

  // Per-divide context captured when the divide is accepted.
  typedef struct packed {
    logic q_neg;  // negate the quotient on commit
    logic r_neg;  // negate the remainder on commit (dividend sign)
    logic dbz;    // divisor was zero: commit the fixed override values
  } div_ctx_t;

endpackage

// File: rtl/hilo_unit_div_core.sv
// Restoring divider iterator: one quotient bit per step, MSB first.
// Operates on unsigned magnitudes only; sign handling lives in the parent.
module hilo_unit_div_core
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH = HILO_LENGTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,     // load operands, clear remainder/counter
  input  logic             step_i,      // perform one iteration
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,      // current step is the final one
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // The dividend register doubles as the quotient shift register: each
  // step shifts one dividend bit out the top and one quotient bit in.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One extra bit on the trial subtract exposes the borrow.
  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Trial subtraction and next-state selection for one iteration.
  always_comb begin
    shifted_s = {rem_q, dvd_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvs_q};
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    if (start_i) begin
      rem_d = {WIDTH{1'b0}};
      dvd_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = {CNT_W{1'b0}};
    end else if (step_i) begin
      if (!diff_s[WIDTH]) begin
        rem_d = diff_s[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted_s[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      rem_d = rem_q;
      dvd_d = dvd_q;
    end
  end

  // Iterator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= {WIDTH{1'b0}};
      dvd_q <= {WIDTH{1'b0}};
      dvs_q <= {WIDTH{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LAST_CNT);
  assign quot_o = dvd_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO architectural register pair plus a 32-iteration DIV/DIVU engine.
// Writes from MULT/MTHI/MTLO land here; divides stall the pipeline via busy.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH = HILO_LENGTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_hilo,
  input  logic [WIDTH-1:0] write_hi,
  input  logic [WIDTH-1:0] write_lo,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_a,
  input  logic [WIDTH-1:0] div_b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             div_done
);

  // Two's-complement negate when en is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic             en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  div_ctx_t         ctx_q, ctx_d;
  // Raw dividend kept for the divide-by-zero HI value.
  logic [WIDTH-1:0] a_raw_q, a_raw_d;

  logic             a_sign_s, b_sign_s;
  logic [WIDTH-1:0] a_abs_s, b_abs_s;
  logic             core_start_s, core_step_s, core_last_s;
  logic [WIDTH-1:0] core_quot_s, core_rem_s;

  // Operand conditioning: magnitudes only for signed divides.
  always_comb begin
    a_sign_s = div_signed & div_a[WIDTH-1];
    b_sign_s = div_signed & div_b[WIDTH-1];
    a_abs_s  = neg_if(div_a, a_sign_s);
    b_abs_s  = neg_if(div_b, b_sign_s);
  end

  // FSM, HI/LO write arbitration and result commit with sign fix-up.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    ctx_d        = ctx_q;
    a_raw_d      = a_raw_q;
    core_start_s = 1'b0;
    core_step_s  = 1'b0;
    case (state_q)
      HILO_IDLE: begin
        if (flush) begin
          state_d = HILO_IDLE;
        end else if (div_start) begin
          // A divide beats a same-cycle HI/LO write.
          core_start_s = 1'b1;
          ctx_d.q_neg  = a_sign_s ^ b_sign_s;
          ctx_d.r_neg  = a_sign_s;
          ctx_d.dbz    = (div_b == {WIDTH{1'b0}});
          a_raw_d      = div_a;
          state_d      = HILO_RUN;
        end else if (w_hilo) begin
          hi_d = write_hi;
          lo_d = write_lo;
        end else begin
          state_d = HILO_IDLE;
        end
      end
      HILO_RUN: begin
        if (flush) begin
          state_d = HILO_IDLE;
        end else begin
          core_step_s = 1'b1;
          if (core_last_s) begin
            state_d = HILO_DONE;
          end else begin
            state_d = HILO_RUN;
          end
        end
      end
      HILO_DONE: begin
        if (flush) begin
          state_d = HILO_IDLE;
        end else begin
          // Divide by zero commits a fixed pattern; no early exit is taken.
          if (ctx_q.dbz) begin
            lo_d = {WIDTH{1'b1}};
            hi_d = a_raw_q;
          end else begin
            lo_d = neg_if(core_quot_s, ctx_q.q_neg);
            hi_d = neg_if(core_rem_s, ctx_q.r_neg);
          end
          state_d = HILO_IDLE;
        end
      end
      default: begin
        state_d = HILO_IDLE;
      end
    endcase
  end

  // Control and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HILO_IDLE;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      ctx_q   <= '0;
      a_raw_q <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ctx_q   <= ctx_d;
      a_raw_q <= a_raw_d;
    end
  end

  hilo_unit_div_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (core_start_s),
    .step_i     (core_step_s),
    .dividend_i (a_abs_s),
    .divisor_i  (b_abs_s),
    .last_o     (core_last_s),
    .quot_o     (core_quot_s),
    .rem_o      (core_rem_s)
  );

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != HILO_IDLE);
  assign div_done = (state_q == HILO_DONE);

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: vector table of divides, randomised
// divides against a behavioural model, and hand-written flush/reset cases.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_hilo = 1'b0;
  logic [31:0] write_hi = 32'd0;
  logic [31:0] write_lo = 32'd0;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_a = 32'd0;
  logic [31:0] div_b = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, div_done;

  int checks = 0;
  int failures = 0;

  // Expected {hi, lo} pushed at divide issue, popped at completion.
  logic [63:0] sb_q[$];

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  vec_t vecs[10];

  hilo_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_hilo     (w_hilo),
    .write_hi   (write_hi),
    .write_lo   (write_lo),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .flush      (flush),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .div_done   (div_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Issue one divide, measure busy length and done pulses, compare result.
  task automatic run_div(input string nm, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int          busy_cyc;
    int          done_cnt;
    logic [63:0] exp;
    sb_q.push_back({exp_hi, exp_lo});
    @(negedge clk);
    div_signed = sg;
    div_a      = a;
    div_b      = b;
    div_start  = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    busy_cyc  = 0;
    done_cnt  = 0;
    while (busy && busy_cyc < 200) begin
      busy_cyc++;
      if (div_done) done_cnt++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, 32'(busy_cyc), 32'd33);
    chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    exp = sb_q.pop_front();
    chk({nm, "_lo"}, lo, exp[31:0]);
    chk({nm, "_hi"}, hi, exp[63:32]);
  endtask

  initial begin
    int done_seen;
    logic [31:0] ra, rb;
    logic signed [31:0] sa, sbv;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[3] = '{1'b0, 32'hDEADBEEF,   32'd0,        32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[5] = '{1'b1, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0};
    vecs[7] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};
    vecs[8] = '{1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 32'd1};
    vecs[9] = '{1'b0, 32'd5,          32'd9,        32'd0,        32'd5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, div_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain HI/LO write in IDLE
    w_hilo   = 1'b1;
    write_hi = 32'h12345678;
    write_lo = 32'h9ABCDEF0;
    @(negedge clk);
    w_hilo = 1'b0;
    chk("whilo_hi", hi, 32'h12345678);
    chk("whilo_lo", lo, 32'h9ABCDEF0);
    chk("whilo_busy", {31'd0, busy}, 32'd0);

    // Table of directed divides
    for (int i = 0; i < 10; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b,
              vecs[i].exp_lo, vecs[i].exp_hi);
    end

    // Random unsigned divides against the language's own operators
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd1;
      run_div($sformatf("rndu%0d", i), 1'b0, ra, rb, ra / rb, ra % rb);
    end

    // Random signed divides (truncating quotient, remainder follows dividend)
    for (int i = 0; i < 4; i++) begin
      sa  = $signed($urandom);
      sbv = $signed($urandom >> $urandom_range(0, 28));
      if (i[0]) sbv = -sbv;
      if (sbv == 32'sd0) sbv = 32'sd3;
      if (sa == 32'sh80000000 && sbv == -32'sd1) sbv = 32'sd5;
      run_div($sformatf("rnds%0d", i), 1'b1, sa, sbv, sa / sbv, sa % sbv);
    end

    // Flush mid-RUN; same-cycle w_hilo with div_start and w_hilo during RUN ignored
    @(negedge clk);
    w_hilo   = 1'b1;
    write_hi = 32'hAA;
    write_lo = 32'hBB;
    @(negedge clk);
    div_signed = 1'b0;
    div_a      = 32'd50;
    div_b      = 32'd5;
    div_start  = 1'b1;
    write_hi   = 32'h333;
    write_lo   = 32'h444;
    @(negedge clk);
    div_start = 1'b0;
    chk("flush_run_busy", {31'd0, busy}, 32'd1);
    done_seen = 0;
    for (int i = 1; i < 10; i++) begin
      if (div_done) done_seen++;
      @(negedge clk);
    end
    chk("run_whilo_ignored_hi", hi, 32'hAA);
    w_hilo = 1'b0;
    flush  = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (div_done) done_seen++;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_no_done", 32'(done_seen), 32'd0);
    chk("flush_hi", hi, 32'hAA);
    chk("flush_lo", lo, 32'hBB);

    // Flush in IDLE blocks div_start and w_hilo
    flush     = 1'b1;
    div_start = 1'b1;
    w_hilo    = 1'b1;
    write_hi  = 32'h555;
    write_lo  = 32'h666;
    @(negedge clk);
    flush     = 1'b0;
    div_start = 1'b0;
    w_hilo    = 1'b0;
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);
    chk("idle_flush_hi", hi, 32'hAA);
    chk("idle_flush_lo", lo, 32'hBB);

    // Asynchronous reset mid-RUN
    div_signed = 1'b0;
    div_a      = 32'd1000;
    div_b      = 32'd3;
    div_start  = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_div("post_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Owns the architectural HI/LO register pair and a multi-cycle iterative divider.
- Sits directly downstream of the ALU. It consumes the ALU's Write_HI/Write_LO/W_HILO requests from MULT/MULTU/MTHI/MTLO.
- It also produces the LO/HI values the ALU reads for MFHI/MFLO.
- It replaces the ALU's single-cycle combinational DIVU with a 32-iteration restoring divider that supports DIV and DIVU, and stalls the pipeline while busy.

Parameters:
- WIDTH, 32, data width. Must equal `LENGTH.
- CNT_W, 5, iteration counter width. Must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- w_hilo  in  1  HI/LO write request from the ALU.
- write_hi  in  WIDTH  value to write to HI.
- write_lo  in  WIDTH  value to write to LO.
- div_start  in  1  start a divide. Single-cycle request.
- div_signed  in  1  1 = DIV, 0 = DIVU. Sampled with div_start.
- div_a  in  WIDTH  dividend (rs).
- div_b  in  WIDTH  divisor (rt).
- flush  in  1  abort an in-flight divide.
- hi  out  WIDTH  registered HI, to the ALU HI input.
- lo  out  WIDTH  registered LO, to the ALU LO input.
- busy  out  1  divider occupied. Pipeline stall request.
- div_done  out  1  one-cycle pulse in the cycle the result is committed.

Behaviour:
- Reset (async, rst_n low):
  - hi = 0, lo = 0, state = IDLE, busy = 0, div_done = 0.
  - Any in-flight divide is discarded.
  - Reset release is synchronous to clk.
- States: IDLE, RUN, DONE.
  - busy = (state != IDLE), combinational from state.
  - div_done = (state == DONE).
- IDLE:
  - On an edge with div_start = 1: latch |div_a| and |div_b| (absolute values only when div_signed = 1), the quotient sign (a_sign XOR b_sign) and the remainder sign (a_sign). Clear the partial remainder and counter, then go to RUN.
  - Otherwise, if w_hilo = 1, hi <= write_hi and lo <= write_lo on that edge.
  - If div_start and w_hilo are both high in the same cycle, div_start wins and w_hilo is ignored.
- RUN:
  - One restoring iteration per edge, MSB first.
  - Partial remainder {r, next dividend bit} minus divisor. If non-negative, keep the difference and shift 1 into the quotient; else keep the shifted value and shift 0.
  - Counter increments each edge. After the WIDTH-th iteration (counter == WIDTH-1), go to DONE.
- DONE:
  - On the edge leaving DONE, lo <= quotient and hi <= remainder, with signed fix-up applied. Next state is IDLE.
- Latency:
  - div_start sampled at edge E0. RUN covers edges E1..E32. HI/LO are updated at E33.
  - busy is high for the 33 cycles between E0 and E33. An MFHI issued after busy falls reads the new value.
- Signed fix-up:
  - Quotient is negated when the quotient sign = 1.
  - Remainder is negated when the remainder sign = 1.
  - The remainder always takes the sign of the dividend.
- Width rules: all arithmetic is WIDTH bits. The partial-remainder subtract uses WIDTH+1 bits to expose the borrow.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives lo = 0x80000000, hi = 0. This is the natural result of the unsigned core with fix-up; no trap is raised.
- Divide by zero (both signednesses):
  - lo = 0xFFFFFFFF, hi = the original div_a value (the raw operand, not its absolute value).
  - Latency is unchanged; there is no early exit.
- Ignored inputs while busy:
  - w_hilo and div_start are ignored. The pipeline is stalled, so these inputs are don't-care.
- flush:
  - In RUN or DONE: return to IDLE on that edge, leave HI/LO unchanged, and do not pulse div_done.
  - In IDLE, flush blocks a same-cycle div_start and w_hilo.
- Reset mid-operation: immediately IDLE with hi = lo = 0.

Decomposition:
- Shared header (head.v), new defines: `HILO_IDLE, `HILO_RUN, `HILO_DONE as 2-bit state encodings. Existing `LENGTH is reused for WIDTH.
- Remove ALU_CONTROL_DIVU's combinational path from the ALU. The decoder drives div_start and div_signed instead.
- One sub-module, div_core: the restoring iterator holding the partial remainder, quotient shift register and counter, with start, step and done signals. hilo_unit owns the FSM, sign handling, the divide-by-zero override and the HI/LO registers.

Test Plan:
- w_hilo = 1, write_hi = 0x12345678, write_lo = 0x9ABCDEF0 in IDLE -> next cycle hi = 0x12345678, lo = 0x9ABCDEF0, busy = 0.
- DIVU 100 / 7 -> busy high for 33 cycles, div_done pulses once, then lo = 14, hi = 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE -> lo = 0xFFFFFFFD, hi = 1.
- DIVU 0xDEADBEEF / 0 -> lo = 0xFFFFFFFF, hi = 0xDEADBEEF after 33 cycles. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Start DIVU 50 / 5 with hi/lo preloaded 0xAA/0xBB, assert flush at cycle 10 -> busy drops next edge, no div_done, hi = 0xAA, lo = 0xBB. Assert w_hilo during RUN -> ignored.
- Start a divide, drop rst_n asynchronously mid-RUN -> busy = 0, hi = lo = 0 immediately. After release, DIVU 9 / 3 -> lo = 3, hi = 0.
